brcmp_iter: RTL

- Multi-cycle branch comparator for area-constrained core builds.
- Sits directly upstream of the branch conditional selector and produces its six flags: eq, ne, lt, ge, ltu, geu.
- Compares rs1/rs2 one CHUNK-bit slice per cycle, MSB slice first, using a start/busy/done handshake with the branch control logic.

---
 rtl/brcmp_pkg.sv | 25 ++
 rtl/brcmp_chunk.sv | 14 +
 rtl/brcmp_iter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/brcmp_pkg.sv
// Shared types and helpers for the iterative branch comparator.
package brcmp_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int CHUNK_DEFAULT = 8;
    localparam int NCH           = XLEN_DEFAULT / CHUNK_DEFAULT;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic int cnt_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    localparam int CNT_W = cnt_width(NCH);

    // Chunk 0 is the most significant slice.
    function automatic int chunk_lsb(input int idx, input int nch, input int chunk);
        return (nch - 1 - idx) * chunk;
    endfunction

endpackage

// File: rtl/brcmp_chunk.sv
// Combinational CHUNK-bit equality and unsigned less-than unit.
module brcmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         chunk_eq_o,
    output logic         chunk_ltu_o
);

    assign chunk_eq_o  = (a_i == b_i);
    assign chunk_ltu_o = (a_i < b_i);

endmodule

// File: rtl/brcmp_iter.sv
// Multi-cycle branch comparator: one CHUNK-bit slice per cycle, MSB slice first.
// Optional macro BRCMP_EARLY_EXIT_EN finishes right after the first differing slice.
module brcmp_iter
    import brcmp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CHUNK = CHUNK_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            eq_o,
    output logic            ne_o,
    output logic            lt_o,
    output logic            ge_o,
    output logic            ltu_o,
    output logic            geu_o
);

    localparam int N_CHUNKS = XLEN / CHUNK;
    localparam int IDX_W    = cnt_width(N_CHUNKS);

    state_t            state_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [IDX_W-1:0]  idx_q;
    logic              diff_q, ltu_r_q;
    logic              busy_q, done_q;
    logic              eq_q, ne_q, lt_q, ge_q, ltu_q, geu_q;

    int                lsb;
    logic [XLEN-1:0]   a_shift, b_shift;
    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic              chunk_eq, chunk_ltu;
    logic              hit, diff_d, ltu_r_d, last, early_exit;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lsb     = chunk_lsb(int'(idx_q), N_CHUNKS, CHUNK);
        a_shift = a_q >> lsb;
        b_shift = b_q >> lsb;
        a_chunk = a_shift[CHUNK-1:0];
        b_chunk = b_shift[CHUNK-1:0];
    end

    brcmp_chunk #(.W(CHUNK)) u_chunk (
        .a_i         (a_chunk),
        .b_i         (b_chunk),
        .chunk_eq_o  (chunk_eq),
        .chunk_ltu_o (chunk_ltu)
    );

    // Only the first differing slice decides; later slices leave the record untouched.
    assign hit     = (state_q == BUSY) && !diff_q && !chunk_eq;
    assign diff_d  = diff_q | hit;
    assign ltu_r_d = hit ? chunk_ltu : ltu_r_q;
    assign last    = (idx_q == IDX_W'(N_CHUNKS - 1));

`ifdef BRCMP_EARLY_EXIT_EN
    assign early_exit = hit;
`else
    assign early_exit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            diff_q  <= 1'b0;
            ltu_r_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            ne_q    <= 1'b0;
            lt_q    <= 1'b0;
            ge_q    <= 1'b0;
            ltu_q   <= 1'b0;
            geu_q   <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // The cycle that shows done is idle but still refuses a new start.
                    if (start_i && !done_q) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        idx_q   <= '0;
                        diff_q  <= 1'b0;
                        ltu_r_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q  <= diff_d;
                    ltu_r_q <= ltu_r_d;
                    if (last || early_exit) begin
                        state_q <= DONE;
                    end else begin
                        idx_q  <= idx_q + IDX_W'(1);
                        busy_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    eq_q    <= ~diff_q;
                    ne_q    <= diff_q;
                    ltu_q   <= diff_q & ltu_r_q;
                    geu_q   <= ~(diff_q & ltu_r_q);
                    lt_q    <= (a_q[XLEN-1] != b_q[XLEN-1]) ? a_q[XLEN-1] : (diff_q & ltu_r_q);
                    ge_q    <= ~((a_q[XLEN-1] != b_q[XLEN-1]) ? a_q[XLEN-1] : (diff_q & ltu_r_q));
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign eq_o   = eq_q;
    assign ne_o   = ne_q;
    assign lt_o   = lt_q;
    assign ge_o   = ge_q;
    assign ltu_o  = ltu_q;
    assign geu_o  = geu_q;

endmodule
